spi_stream_reader: RTL and testbench

- SPI-mode-0 master that reads a burst of consecutive 32-bit words from external SPI RAM/flash.
- Issues one READ command with a start address, then streams words out on a valid/ready interface.
- Sits directly upstream of the SPRAM loader/copy stage and replaces its per-word command/address overhead with a single command per burst.
- The consumer writes each accepted word into SPRAM.

---
 rtl/spi_stream_reader_if.sv | 24 ++
 rtl/spi_stream_reader.sv | 213 +++++++++++++++++++++
 tb/tb_spi_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_stream_reader_if.sv
// Request/stream handshake between spi_stream_reader and its requester/consumer.
// The master modport is the side that requests bursts and accepts words.
interface spi_stream_reader_if #(
  parameter int ADDR_BITS = 24,
  parameter int LEN_BITS  = 14
) ();
  logic                 start;
  logic [ADDR_BITS-1:0] addr_in;
  logic [LEN_BITS-1:0]  len_in;
  logic                 busy;
  logic [31:0]          data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output start, addr_in, len_in, data_ready,
    input  busy, data_out, data_valid
  );

  modport slave (
    input  start, addr_in, len_in, data_ready,
    output busy, data_out, data_valid
  );
endinterface

// File: rtl/spi_stream_reader.sv
// SPI mode-0 burst reader: one READ command + address, then a stream of 32-bit words.
// Define SPI_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks after the address.
module spi_stream_reader #(
  parameter int ADDR_BITS = 24,
  parameter int LEN_BITS  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_miso,
  output logic               spi_select,
  output logic               spi_clk_out,
  output logic               spi_mosi,
  spi_stream_reader_if.slave bus
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
  localparam int                  HDR_W     = 8 + ADDR_BITS;
  localparam logic [7:0]          ADDR_LAST = 8'(ADDR_BITS - 1);
  localparam logic [LEN_BITS-1:0] WORD_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] WORD_ZERO = {LEN_BITS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_HOLD  = 3'd4,
`ifdef SPI_FAST_READ_EN
    ST_DUMMY = 3'd6,
`endif
    ST_DESEL = 3'd5
  } state_t;

  state_t              state_r;
  logic                phase_r;
  logic [7:0]          bit_cnt_r;
  logic [HDR_W-1:0]    tx_r;
  logic [31:0]         rx_r;
  logic [LEN_BITS-1:0] words_r;
  logic                sel_r;
  logic                sclk_r;
  logic                mosi_r;
  logic [31:0]         data_r;
  logic                valid_r;
  logic                busy_r;
  logic [31:0]         rx_next_s;

  assign rx_next_s = {rx_r[30:0], spi_miso};

  // Burst sequencer: phase_r=0 is the low half of a bit, phase_r=1 the high half.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= 1'b0;
      bit_cnt_r <= 8'd0;
      tx_r      <= {HDR_W{1'b0}};
      rx_r      <= 32'd0;
      words_r   <= WORD_ZERO;
      sel_r     <= 1'b1;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      data_r    <= 32'd0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sel_r     <= 1'b1;
          sclk_r    <= 1'b0;
          mosi_r    <= 1'b0;
          phase_r   <= 1'b0;
          bit_cnt_r <= 8'd0;
          if (bus.start && (bus.len_in != WORD_ZERO)) begin
            state_r <= ST_CMD;
            busy_r  <= 1'b1;
            sel_r   <= 1'b0;
            words_r <= bus.len_in;
            mosi_r  <= CMD_BYTE[7];
            tx_r    <= {CMD_BYTE[6:0], bus.addr_in, 1'b0};
          end
        end

        ST_CMD: begin
          if (!phase_r) begin
            sclk_r  <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            sclk_r  <= 1'b0;
            phase_r <= 1'b0;
            mosi_r  <= tx_r[HDR_W-1];
            tx_r    <= {tx_r[HDR_W-2:0], 1'b0};
            if (bit_cnt_r == 8'd7) begin
              bit_cnt_r <= 8'd0;
              state_r   <= ST_ADDR;
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end

        ST_ADDR: begin
          if (!phase_r) begin
            sclk_r  <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            sclk_r  <= 1'b0;
            phase_r <= 1'b0;
            if (bit_cnt_r == ADDR_LAST) begin
              bit_cnt_r <= 8'd0;
              mosi_r    <= 1'b0;
`ifdef SPI_FAST_READ_EN
              state_r   <= ST_DUMMY;
`else
              state_r   <= ST_DATA;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
              mosi_r    <= tx_r[HDR_W-1];
              tx_r      <= {tx_r[HDR_W-2:0], 1'b0};
            end
          end
        end

`ifdef SPI_FAST_READ_EN
        ST_DUMMY: begin
          mosi_r <= 1'b0;
          if (!phase_r) begin
            sclk_r  <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            sclk_r  <= 1'b0;
            phase_r <= 1'b0;
            if (bit_cnt_r == 8'd7) begin
              bit_cnt_r <= 8'd0;
              state_r   <= ST_DATA;
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
`endif

        // miso is captured on the edge that ends each high phase
        ST_DATA: begin
          mosi_r <= 1'b0;
          if (!phase_r) begin
            sclk_r  <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            sclk_r  <= 1'b0;
            phase_r <= 1'b0;
            rx_r    <= rx_next_s;
            if (bit_cnt_r == 8'd31) begin
              bit_cnt_r <= 8'd0;
              data_r    <= rx_next_s;
              valid_r   <= 1'b1;
              state_r   <= ST_HOLD;
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end

        // Clock parked low pauses the device; one idle cycle follows each accept.
        ST_HOLD: begin
          sclk_r  <= 1'b0;
          phase_r <= 1'b0;
          if (valid_r) begin
            if (bus.data_ready) begin
              valid_r <= 1'b0;
              words_r <= words_r - WORD_ONE;
              if (words_r == WORD_ONE) begin
                state_r <= ST_DESEL;
                sel_r   <= 1'b1;
              end
            end
          end else begin
            bit_cnt_r <= 8'd0;
            state_r   <= ST_DATA;
          end
        end

        ST_DESEL: begin
          sel_r   <= 1'b1;
          sclk_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          sel_r   <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_select     = sel_r;
  assign spi_clk_out    = sclk_r;
  assign spi_mosi       = mosi_r;
  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_spi_stream_reader.sv
// Directed bench for spi_stream_reader with a cycle-accurate SPI mode-0 device model.
`timescale 1ns/1ps
module tb_spi_stream_reader;

  localparam int AB = 24;
  localparam int LB = 14;
`ifdef SPI_FAST_READ_EN
  localparam int         DUM       = 8;
  localparam logic [7:0] CMD       = 8'h0B;
  localparam int         FIRST_CYC = 145;
`else
  localparam int         DUM       = 0;
  localparam logic [7:0] CMD       = 8'h03;
  localparam int         FIRST_CYC = 129;
`endif
  localparam int HDR = 8 + AB;
  localparam int PRE = HDR + DUM;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic spi_miso = 1'b0;
  wire  spi_select;
  wire  spi_clk_out;
  wire  spi_mosi;

  spi_stream_reader_if #(.ADDR_BITS(AB), .LEN_BITS(LB)) bus ();

  spi_stream_reader #(.ADDR_BITS(AB), .LEN_BITS(LB)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_miso    (spi_miso),
    .spi_select  (spi_select),
    .spi_clk_out (spi_clk_out),
    .spi_mosi    (spi_mosi),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Device model: samples mosi on sclk rise, shifts the next data bit out after sclk fall.
  logic        dev_sclk_q     = 1'b0;
  logic        dev_sel_q      = 1'b1;
  int          dev_rise       = 0;
  int          dev_burst_rise = 0;
  int          sel_fall_cnt   = 0;
  logic [31:0] dev_cmd_addr   = 32'h0;
  logic        dev_mosi_err   = 1'b0;
  logic [31:0] dev_words [0:3];

  function automatic logic dev_bit(input int idx);
    int w;
    int b;
    w = idx / 32;
    b = 31 - (idx % 32);
    if (w > 3) return 1'b0;
    return dev_words[w][b];
  endfunction

  always @(posedge clk) begin
    dev_sclk_q <= spi_clk_out;
    dev_sel_q  <= spi_select;
    if (!spi_select && dev_sel_q) sel_fall_cnt <= sel_fall_cnt + 1;
    if (spi_select && !dev_sel_q) dev_burst_rise <= dev_rise;
    if (spi_select) begin
      dev_rise <= 0;
    end else if (spi_clk_out && !dev_sclk_q) begin
      if (dev_rise < HDR) dev_cmd_addr <= {dev_cmd_addr[30:0], spi_mosi};
      else if (spi_mosi) dev_mosi_err <= 1'b1;
      dev_rise <= dev_rise + 1;
    end else if (!spi_clk_out && dev_sclk_q && (dev_rise >= PRE)) begin
      spi_miso <= dev_bit(dev_rise - PRE);
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [AB-1:0] a, input logic [LB-1:0] n, output int s);
    bus.addr_in = a;
    bus.len_in  = n;
    bus.start   = 1'b1;
    s           = cyc;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_word(input string tag, input int s, output int at, output logic [31:0] d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_value(tag, 32'(ok), 32'd1);
    at = cyc - s;
    d  = bus.data_out;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      tick();
    end
    check_value(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    int          at1;
    int          at2;
    int          at3;
    int          f0;
    int          bad;
    logic [31:0] d;

    bus.start      = 1'b0;
    bus.addr_in    = '0;
    bus.len_in     = '0;
    bus.data_ready = 1'b0;
    dev_words[0]   = 32'h0;
    dev_words[1]   = 32'h0;
    dev_words[2]   = 32'h0;
    dev_words[3]   = 32'h0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check_value("rst_select", 32'(spi_select), 32'd1);
    check_value("rst_sclk",   32'(spi_clk_out), 32'd0);
    check_value("rst_mosi",   32'(spi_mosi), 32'd0);
    check_value("rst_data",   bus.data_out, 32'd0);
    check_value("rst_valid",  32'(bus.data_valid), 32'd0);
    check_value("rst_busy",   32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    // single word
    dev_words[0]   = 32'hDEADBEEF;
    bus.data_ready = 1'b1;
    f0 = sel_fall_cnt;
    start_burst(24'h001234, 14'd1, s);
    check_value("t1_busy_c1",   32'(bus.busy), 32'd1);
    check_value("t1_select_c1", 32'(spi_select), 32'd0);
    wait_word("t1_timeout", s, at1, d);
    check_value("t1_latency", 32'(at1), 32'(FIRST_CYC));
    check_value("t1_data", d, 32'hDEADBEEF);
    tick();
    check_value("t1_valid_drop", 32'(bus.data_valid), 32'd0);
    check_value("t1_desel_sel",  32'(spi_select), 32'd1);
    check_value("t1_desel_busy", 32'(bus.busy), 32'd1);
    tick();
    check_value("t1_busy_low", 32'(bus.busy), 32'd0);
    check_value("t1_cmd_addr", dev_cmd_addr, {CMD, 24'h001234});
    check_value("t1_sclks", 32'(dev_burst_rise), 32'(PRE + 32));
    check_value("t1_bursts", 32'(sel_fall_cnt - f0), 32'd1);

    // burst of 3 with data_ready high
    dev_words[0] = 32'h11111111;
    dev_words[1] = 32'h22222222;
    dev_words[2] = 32'h33333333;
    f0 = sel_fall_cnt;
    start_burst(24'h000100, 14'd3, s);
    wait_word("t2_w1_timeout", s, at1, d);
    check_value("t2_w1_lat", 32'(at1), 32'(FIRST_CYC));
    check_value("t2_w1", d, 32'h11111111);
    wait_word("t2_w2_timeout", s, at2, d);
    check_value("t2_w2", d, 32'h22222222);
    check_value("t2_gap12", 32'(at2 - at1), 32'd66);
    wait_word("t2_w3_timeout", s, at3, d);
    check_value("t2_w3", d, 32'h33333333);
    check_value("t2_gap23", 32'(at3 - at2), 32'd66);
    wait_idle("t2_idle");
    check_value("t2_bursts", 32'(sel_fall_cnt - f0), 32'd1);
    check_value("t2_sclks", 32'(dev_burst_rise), 32'(PRE + 96));
    check_value("t2_cmd_addr", dev_cmd_addr, {CMD, 24'h000100});

    // backpressure on word 2
    tick();
    start_burst(24'h000100, 14'd3, s);
    wait_word("t3_w1_timeout", s, at1, d);
    check_value("t3_w1", d, 32'h11111111);
    tick();
    bus.data_ready = 1'b0;
    wait_word("t3_w2_timeout", s, at2, d);
    check_value("t3_w2", d, 32'h22222222);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (spi_clk_out !== 1'b0 || bus.data_out !== 32'h22222222 || bus.data_valid !== 1'b1) bad++;
      tick();
    end
    check_value("t3_frozen", 32'(bad), 32'd0);
    bus.data_ready = 1'b1;
    wait_word("t3_w3_timeout", s, at3, d);
    check_value("t3_w3", d, 32'h33333333);
    check_value("t3_gap23", 32'(at3 - at2), 32'd86);
    wait_idle("t3_idle");

    // len_in = 0 is ignored
    tick();
    start_burst(24'h00FF00, 14'd0, s);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0 || spi_select !== 1'b1) bad++;
      tick();
    end
    check_value("t4_len0", 32'(bad), 32'd0);

    // start pulsed mid-burst is ignored
    dev_words[0] = 32'hA5A5A5A5;
    dev_words[1] = 32'h5A5A5A5A;
    f0 = sel_fall_cnt;
    start_burst(24'h000200, 14'd2, s);
    repeat (49) tick();
    bus.addr_in = 24'h00FFFF;
    bus.len_in  = 14'd5;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    wait_word("t4_w1_timeout", s, at1, d);
    check_value("t4_w1_lat", 32'(at1), 32'(FIRST_CYC));
    check_value("t4_w1", d, 32'hA5A5A5A5);
    wait_word("t4_w2_timeout", s, at2, d);
    check_value("t4_w2", d, 32'h5A5A5A5A);
    wait_idle("t4_idle");
    repeat (3) tick();
    check_value("t4_no_restart", 32'(bus.busy), 32'd0);
    check_value("t4_bursts", 32'(sel_fall_cnt - f0), 32'd1);
    check_value("t4_sclks", 32'(dev_burst_rise), 32'(PRE + 64));
    check_value("t4_cmd_addr", dev_cmd_addr, {CMD, 24'h000200});

    // reset at cycle 50 of a burst, then a fresh burst
    start_burst(24'h000300, 14'd3, s);
    repeat (49) tick();
    rst = 1'b1;
    tick();
    check_value("t5_rst_select", 32'(spi_select), 32'd1);
    check_value("t5_rst_busy",   32'(bus.busy), 32'd0);
    check_value("t5_rst_valid",  32'(bus.data_valid), 32'd0);
    check_value("t5_rst_sclk",   32'(spi_clk_out), 32'd0);
    rst = 1'b0;
    tick();
    dev_words[0] = 32'hCAFEF00D;
    start_burst(24'h00ABCD, 14'd1, s);
    wait_word("t5_timeout", s, at1, d);
    check_value("t5_latency", 32'(at1), 32'(FIRST_CYC));
    check_value("t5_data", d, 32'hCAFEF00D);
    wait_idle("t5_idle");
    check_value("t5_cmd_addr", dev_cmd_addr, {CMD, 24'h00ABCD});
    check_value("mosi_low_after_addr", 32'(dev_mosi_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
